// File: rtl/centroid_div_pkg.sv
// centroid_div_pkg: shared widths and state encoding for the centroid divider
package centroid_div_pkg;
  localparam int NUM_WIDTH = 24;
  localparam int DEN_WIDTH = 16;
  localparam int Q_WIDTH   = 10;
  localparam int CNT_WIDTH = $clog2(NUM_WIDTH);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/centroid_div.sv
// centroid_div: restoring radix-2 divider NUM/DEN with saturation and zero-divisor flag; CENTROID_DIV_ROUND_EN adds round-half-up
module centroid_div
  import centroid_div_pkg::*;
#(
  parameter int NUM_WIDTH = centroid_div_pkg::NUM_WIDTH,
  parameter int DEN_WIDTH = centroid_div_pkg::DEN_WIDTH,
  parameter int Q_WIDTH   = centroid_div_pkg::Q_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 iSTART,
  input  logic                 iABORT,
  input  logic [NUM_WIDTH-1:0] iNUM,
  input  logic [DEN_WIDTH-1:0] iDEN,
  output logic                 oBUSY,
  output logic                 oVALID,
  output logic [Q_WIDTH-1:0]   oQ,
  output logic                 oERR,
  output logic                 oSAT
);
  localparam int CW = $clog2(NUM_WIDTH);
  state_t               state_q, state_d;
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic [DEN_WIDTH-1:0] den_q, den_d;
  logic [DEN_WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [Q_WIDTH-1:0]   q_q;
  logic                 err_q, sat_q;
  logic [DEN_WIDTH:0]   sh;
  logic                 ge;
  logic                 err_n, sat_n;
`ifdef CENTROID_DIV_ROUND_EN
  logic                 rnd;
  assign rnd = {rem_q, 1'b0} >= {2'b0, den_q};
`endif
  assign sh     = {rem_q[DEN_WIDTH-1:0], num_q[NUM_WIDTH-1]};
  assign ge     = sh >= {1'b0, den_q};
  assign err_n  = state_q == IDLE;
  assign sat_n  = |num_d[NUM_WIDTH-1:Q_WIDTH];
  assign oBUSY  = state_q != IDLE;
  assign oVALID = state_q == DONE;
  assign oQ     = q_q;
  assign oERR   = err_q;
  assign oSAT   = sat_q;
  // next state and one shift/subtract step per CALC cycle; abort overrides everything
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (iSTART) begin
        num_d   = iNUM;
        den_d   = iDEN;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = iDEN == '0 ? DONE : CALC;
      end
      CALC: begin
        rem_d = ge ? sh - {1'b0, den_q} : sh;
        num_d = {num_q[NUM_WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
`ifdef CENTROID_DIV_ROUND_EN
        if (cnt_q == CW'(NUM_WIDTH - 1)) state_d = RND;
`else
        if (cnt_q == CW'(NUM_WIDTH - 1)) state_d = DONE;
`endif
      end
`ifdef CENTROID_DIV_ROUND_EN
      RND: begin
        num_d   = num_q + NUM_WIDTH'(rnd);
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (iABORT) state_d = IDLE;
  end
  // state/datapath registers; results latch on the edge entering DONE only
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      if (state_d == DONE) begin
        q_q   <= err_n ? '0 : sat_n ? '1 : num_d[Q_WIDTH-1:0];
        err_q <= err_n;
        sat_q <= !err_n && sat_n;
      end
    end
  end
endmodule

// File: tb/tb_centroid_div.sv
// tb_centroid_div: directed checks of latency, quotient, saturation, zero divisor, busy, abort and reset
module tb_centroid_div;
`ifdef CENTROID_DIV_ROUND_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif
  localparam int LAT = 25 + RL;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        iSTART = 1'b0;
  logic        iABORT = 1'b0;
  logic [23:0] iNUM = '0;
  logic [15:0] iDEN = '0;
  logic        oBUSY, oVALID, oERR, oSAT;
  logic [9:0]  oQ;
  int checks = 0;
  int failures = 0;
  int lat;
  int nv;
  bit busy_ok;

  centroid_div dut (
    .CLK(CLK), .RST_N(RST_N), .iSTART(iSTART), .iABORT(iABORT),
    .iNUM(iNUM), .iDEN(iDEN), .oBUSY(oBUSY), .oVALID(oVALID),
    .oQ(oQ), .oERR(oERR), .oSAT(oSAT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] n, input logic [15:0] d);
    @(posedge CLK); #1;
    iNUM = n;
    iDEN = d;
    iSTART = 1'b1;
    @(posedge CLK); #1;
    iSTART = 1'b0;
  endtask

  task automatic wait_valid(input int n0, output int n, output bit bok);
    n = n0;
    bok = 1'b1;
    while (!oVALID && n < 80) begin
      bok &= oBUSY;
      @(posedge CLK); #1;
      n++;
    end
    bok &= oBUSY;
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (oVALID) cnt++;
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", oBUSY, 0);
    chk("rst_valid", oVALID, 0);
    chk("rst_q", oQ, 0);
    chk("rst_err", oERR, 0);
    chk("rst_sat", oSAT, 0);
    @(negedge CLK); RST_N = 1'b1;

    start(1000, 10);
    wait_valid(1, lat, busy_ok);
    chk("exact_lat", lat, LAT);
    chk("exact_busy", busy_ok, 1);
    chk("exact_q", oQ, 100);
    chk("exact_err", oERR, 0);
    chk("exact_sat", oSAT, 0);
    @(posedge CLK); #1;
    chk("post_valid", oVALID, 0);
    chk("post_busy", oBUSY, 0);
    chk("post_hold_q", oQ, 100);

    start(25, 10);
    wait_valid(1, lat, busy_ok);
    chk("round_25_q", oQ, 2 + RL);
    start(24, 10);
    wait_valid(1, lat, busy_ok);
    chk("round_24_q", oQ, 2);

    start(500, 0);
    wait_valid(1, lat, busy_ok);
    chk("zero_lat", lat, 1);
    chk("zero_busy", busy_ok, 1);
    chk("zero_q", oQ, 0);
    chk("zero_err", oERR, 1);
    chk("zero_sat", oSAT, 0);
    start(9, 3);
    wait_valid(1, lat, busy_ok);
    chk("after_zero_lat", lat, LAT);
    chk("after_zero_q", oQ, 3);
    chk("after_zero_err", oERR, 0);

    start(20000, 1);
    wait_valid(1, lat, busy_ok);
    chk("sat_q", oQ, 1023);
    chk("sat_flag", oSAT, 1);
    start(1023, 1);
    wait_valid(1, lat, busy_ok);
    chk("nosat_q", oQ, 1023);
    chk("nosat_flag", oSAT, 0);

    start(100, 4);
    repeat (4) begin @(posedge CLK); #1; end
    iNUM = 7; iDEN = 1; iSTART = 1'b1;
    @(posedge CLK); #1;
    iSTART = 1'b0;
    wait_valid(6, lat, busy_ok);
    chk("busy_lat", lat, LAT);
    chk("busy_q", oQ, 25);
    count_valids(35, nv);
    chk("busy_no_second", nv, 0);
    chk("busy_idle", oBUSY, 0);

    start(1000, 10);
    repeat (9) begin @(posedge CLK); #1; end
    iABORT = 1'b1;
    @(posedge CLK); #1;
    iABORT = 1'b0;
    chk("abort_busy", oBUSY, 0);
    count_valids(35, nv);
    chk("abort_no_valid", nv, 0);
    chk("abort_hold_q", oQ, 25);

    @(posedge CLK); #1;
    iNUM = 9; iDEN = 3; iSTART = 1'b1; iABORT = 1'b1;
    @(posedge CLK); #1;
    iSTART = 1'b0; iABORT = 1'b0;
    chk("abort_start_idle", oBUSY, 0);

    start(100, 4);
    repeat (11) begin @(posedge CLK); #1; end
    RST_N = 1'b0;
    #1;
    chk("midrst_busy", oBUSY, 0);
    chk("midrst_valid", oVALID, 0);
    chk("midrst_q", oQ, 0);
    chk("midrst_err", oERR, 0);
    chk("midrst_sat", oSAT, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    start(64, 8);
    wait_valid(1, lat, busy_ok);
    chk("postrst_lat", lat, LAT);
    chk("postrst_busy", busy_ok, 1);
    chk("postrst_q", oQ, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
